// File: rtl/alu_result_stage_pkg.sv
// Shared ALU result-path types: flag bit positions and the buffered result record.
package ALUOperations;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_FLAG_W = 7;
  localparam int ALU_RD_W   = 5;

  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_ODDPAR  = 1;
  localparam int FLAG_EVENPAR = 2;
  localparam int FLAG_OVF     = 3;
  localparam int FLAG_NEG     = 4;
  localparam int FLAG_ZERO    = 5;
  localparam int FLAG_DIVZ    = 6;

  typedef struct packed {
    logic divz;
    logic zero;
    logic neg;
    logic ovf;
    logic even_par;
    logic odd_par;
    logic carry;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    alu_flags_t            flags;
    logic [ALU_RD_W-1:0]   rd;
    logic                  wr_en;
    logic                  flags_wr_en;
  } alu_result_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready buffer (head + skid) with a registered ready and a
// synchronous clear; both entries are exported so the parent can inspect them.
module alu_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         main_valid,
  output logic [W-1:0] main_data,
  output logic         skid_valid,
  output logic [W-1:0] skid_data
);

  logic push, pop;
  logic main_vld_n, skid_vld_n;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = main_valid & out_ready;

  // skid_valid implies main_valid; a full buffer never accepts
  always_comb begin
    main_vld_n = main_valid;
    skid_vld_n = skid_valid;
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (skid_valid) begin
      if (pop) skid_vld_n = 1'b0;
    end else if (main_valid) begin
      if (push && !pop)      skid_vld_n = 1'b1;
      else if (pop && !push) main_vld_n = 1'b0;
    end else begin
      main_vld_n = push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_vld_n;
      skid_valid <= skid_vld_n;
      in_ready   <= ~skid_vld_n;
      if (skid_valid && pop)
        main_data <= skid_data;
      else if (push && (!main_valid || pop))
        main_data <= in_data;
      if (push && main_valid && !pop)
        skid_data <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: FIFO-ordered result buffer, architectural
// status-flag register and carry forwarding back to the ALU.
module alu_result_stage
  import ALUOperations::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int FLAG_W = ALU_FLAG_W,
  parameter int RD_W   = ALU_RD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inResult,
  input  logic [FLAG_W-1:0] inFlags,
  input  logic [RD_W-1:0]   inRd,
  input  logic              inWrEn,
  input  logic              inFlagsWrEn,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outResult,
  output logic [RD_W-1:0]   outRd,
  output logic              outWrEn,
  output logic [FLAG_W-1:0] statusFlags,
  output logic              carryFwd
);

  localparam int PAY_W = $bits(alu_result_t);

  alu_result_t in_ent, main_ent, skid_ent;
  alu_flags_t  status_q;
  logic        main_vld, skid_vld;
  logic        skid_unused;

  assign in_ent = {inResult, inFlags, inRd, inWrEn, inFlagsWrEn};

  alu_skid_buffer #(.W(PAY_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (in_ent),
    .out_ready  (outReady),
    .main_valid (main_vld),
    .main_data  (main_ent),
    .skid_valid (skid_vld),
    .skid_data  (skid_ent)
  );

  assign outValid    = main_vld;
  assign outResult   = main_ent.result;
  assign outRd       = main_ent.rd;
  assign outWrEn     = main_ent.wr_en;
  assign statusFlags = status_q;

  // Commit happens on retire, independent of flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      status_q <= '0;
    else if (main_vld && outReady && main_ent.flags_wr_en)
      status_q <= main_ent.flags;
  end

  // Youngest flag-writing entry wins; skid is younger than main
  always_comb begin
    carryFwd = status_q[FLAG_CARRY];
    if (skid_vld && skid_ent.flags_wr_en)
      carryFwd = skid_ent.flags[FLAG_CARRY];
    else if (main_vld && main_ent.flags_wr_en)
      carryFwd = main_ent.flags[FLAG_CARRY];
  end

  assign skid_unused = ^{skid_ent.result, skid_ent.rd, skid_ent.wr_en,
                         skid_ent.flags[ALU_FLAG_W-1:FLAG_CARRY+1]};

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, inValid, inReady, inWrEn, inFlagsWrEn;
  logic [31:0] inResult, outResult;
  logic [6:0]  inFlags, statusFlags;
  logic [4:0]  inRd, outRd;
  logic        outValid, outReady, outWrEn, carryFwd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inResult(inResult),
    .inFlags(inFlags), .inRd(inRd), .inWrEn(inWrEn), .inFlagsWrEn(inFlagsWrEn),
    .outValid(outValid), .outReady(outReady), .outResult(outResult),
    .outRd(outRd), .outWrEn(outWrEn), .statusFlags(statusFlags), .carryFwd(carryFwd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [6:0] f, input logic fw);
    inValid     = v;
    inResult    = r;
    inFlags     = f;
    inFlagsWrEn = fw;
    inRd        = r[4:0];
    inWrEn      = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; outReady = 1'b0;
    drive(1'b0, 32'h0, 7'h0, 1'b0);

    // 1. reset
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_status", statusFlags, 0);
    chk("rst_carry", carryFwd, 0);
    chk("rst_outResult", outResult, 0);
    #12 rst_n = 1'b1;
    step();
    chk("rst_inReady", inReady, 1);

    // 2. streaming
    outReady = 1'b1;
    drive(1'b1, 32'h1, 7'h41, 1'b1);
    step();
    chk("str_v1", outValid, 1);
    chk("str_d1", outResult, 32'h1);
    drive(1'b1, 32'h2, 7'h20, 1'b1);
    step();
    chk("str_d2", outResult, 32'h2);
    chk("str_st1", statusFlags, 7'h41);
    chk("str_rdy", inReady, 1);
    chk("str_fwd2", carryFwd, 0);
    drive(1'b1, 32'h3, 7'h01, 1'b1);
    step();
    chk("str_d3", outResult, 32'h3);
    chk("str_st2", statusFlags, 7'h20);
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    step();
    chk("str_empty", outValid, 0);
    chk("str_st3", statusFlags, 7'h01);
    chk("str_carry", carryFwd, 1);

    // 3. backpressure
    outReady = 1'b0;
    drive(1'b1, 32'hA, 7'h0, 1'b0);
    step();
    chk("bp_rdy1", inReady, 1);
    chk("bp_dA", outResult, 32'hA);
    drive(1'b1, 32'hB, 7'h0, 1'b0);
    step();
    chk("bp_rdy2", inReady, 0);
    chk("bp_holdA", outResult, 32'hA);
    drive(1'b1, 32'hC, 7'h0, 1'b0);
    step();
    chk("bp_rdy3", inReady, 0);
    chk("bp_stableA", outResult, 32'hA);
    chk("bp_stableV", outValid, 1);
    outReady = 1'b1;
    step();
    chk("bp_dB", outResult, 32'hB);
    chk("bp_rdy4", inReady, 1);
    step();
    chk("bp_dC", outResult, 32'hC);
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    step();
    chk("bp_empty", outValid, 0);
    chk("bp_st", statusFlags, 7'h01);

    // 4. forwarding
    drive(1'b1, 32'h10, 7'h00, 1'b1);
    step();
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    step();
    chk("fw_st0", statusFlags, 7'h00);
    chk("fw_c0", carryFwd, 0);
    outReady = 1'b0;
    drive(1'b1, 32'h11, 7'h01, 1'b1);
    step();
    chk("fw_c1", carryFwd, 1);
    drive(1'b1, 32'h12, 7'h00, 1'b0);
    step();
    chk("fw_c2", carryFwd, 1);
    chk("fw_st1", statusFlags, 7'h00);
    chk("fw_full", inReady, 0);
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    outReady = 1'b1;
    step();
    chk("fw_d12", outResult, 32'h12);
    chk("fw_st2", statusFlags, 7'h01);
    chk("fw_c3", carryFwd, 1);
    step();
    chk("fw_empty", outValid, 0);
    chk("fw_st3", statusFlags, 7'h01);
    chk("fw_c4", carryFwd, 1);

    // 5a. flush at occupancy 2 with an accept attempt
    outReady = 1'b0;
    drive(1'b1, 32'h20, 7'h7f, 1'b1);
    step();
    drive(1'b1, 32'h21, 7'h00, 1'b1);
    step();
    chk("fl_c_skid", carryFwd, 0);
    drive(1'b1, 32'h22, 7'h00, 1'b1);
    flush = 1'b1;
    step();
    chk("fl_v", outValid, 0);
    chk("fl_rdy", inReady, 1);
    chk("fl_st", statusFlags, 7'h01);
    chk("fl_c", carryFwd, 1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    step();
    chk("fl_v2", outValid, 0);

    // 5b. retire commits in the flush cycle; accept is dropped
    outReady = 1'b1;
    drive(1'b1, 32'h23, 7'h02, 1'b1);
    step();
    chk("flb_v", outValid, 1);
    drive(1'b1, 32'h24, 7'h04, 1'b1);
    flush = 1'b1;
    step();
    chk("flb_st", statusFlags, 7'h02);
    chk("flb_v2", outValid, 0);
    chk("flb_rdy", inReady, 1);
    chk("flb_c", carryFwd, 0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    step();
    chk("flb_v3", outValid, 0);
    chk("flb_st2", statusFlags, 7'h02);

    // 6. async reset at occupancy 2
    outReady = 1'b0;
    drive(1'b1, 32'h30, 7'h01, 1'b1);
    step();
    drive(1'b1, 32'h31, 7'h01, 1'b1);
    step();
    chk("ar_full", inReady, 0);
    chk("ar_c", carryFwd, 1);
    drive(1'b0, 32'h0, 7'h0, 1'b0);
    outReady = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("ar_v", outValid, 0);
    chk("ar_d", outResult, 0);
    chk("ar_st", statusFlags, 0);
    chk("ar_c0", carryFwd, 0);
    step();
    #1 rst_n = 1'b1;
    step();
    chk("ar_rdy", inReady, 1);
    chk("ar_v2", outValid, 0);
    chk("ar_st2", statusFlags, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
